// File: rtl/fetch_unit.sv
// fetch_unit: Y86 fetch stage.
// Owns F_predPC, reads the instruction at f_pc_i with 1-3 aligned word reads
// (req/ack handshake), splits it into fields and computes valP / predPC.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   f_pc_i, f_redirect_i      selected PC, redirect pulse
//   F_predPC_o                predicted-PC register back to the PC selector
//   imem_req_o/addr_o         word read request (held until ack), aligned address
//   imem_ack_i/err_i/rdata_i  read completion, fault flag, little-endian data
//   f_valid_o, d_ready_i      decoded instruction handshake to the D stage
//   f_icode_o .. f_stat_o     decoded fields, valC, valP, status
module fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] f_pc_i,
   input  logic        f_redirect_i,
   output logic [31:0] F_predPC_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic        imem_err_i,
   input  logic [31:0] imem_rdata_i,
   output logic        f_valid_o,
   input  logic        d_ready_i,
   output logic [3:0]  f_icode_o,
   output logic [3:0]  f_ifun_o,
   output logic [3:0]  f_rA_o,
   output logic [3:0]  f_rB_o,
   output logic [31:0] f_valC_o,
   output logic [31:0] f_valP_o,
   output logic [2:0]  f_stat_o
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_DRAIN,
      S_VALID,
      S_STOPPED
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] predpc_q, predpc_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  wcnt_q, wcnt_d;
   logic [7:0]  to_q, to_d;
   logic [31:0] w0_q, w0_d;
   logic [31:0] w1_q, w1_d;
   logic        valid_q, valid_d;
   logic [3:0]  icode_q, icode_d;
   logic [3:0]  ifun_q, ifun_d;
   logic [3:0]  ra_q, ra_d;
   logic [3:0]  rb_q, rb_d;
   logic [31:0] valc_q, valc_d;
   logic [31:0] valp_q, valp_d;
   logic [2:0]  stat_q, stat_d;

   logic [71:0] line;
   logic [47:0] ib;
   logic [3:0]  dec_icode;
   logic [3:0]  dec_ifun;
   logic [2:0]  dec_len;
   logic [3:0]  span;
   logic        dec_last;
   logic [3:0]  dec_ra;
   logic [3:0]  dec_rb;
   logic [31:0] dec_valc;
   logic [31:0] dec_valp;
   logic [2:0]  dec_stat;
   logic        fault;
   logic        done;

   function automatic logic [2:0] ins_len(input logic [3:0] ic);
      case (ic)
         4'h2, 4'h6, 4'hA, 4'hB: ins_len = 3'd2;
         4'h7, 4'h8:             ins_len = 3'd5;
         4'h3, 4'h4, 4'h5:       ins_len = 3'd6;
         default:                ins_len = 3'd1;
      endcase
   endfunction

   function automatic logic has_regs(input logic [3:0] ic);
      case (ic)
         4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
         default:                                  has_regs = 1'b0;
      endcase
   endfunction

   // Instruction bytes never extend past byte 0 of the third word, so the
   // assembled line is 9 bytes. The word arriving this cycle is merged in so
   // the final ack can be decoded without an extra cycle.
   always_comb begin
      line = {8'h00, w1_q, w0_q};
      case (wcnt_q)
         2'd0:    line[31:0]  = imem_rdata_i;
         2'd1:    line[63:32] = imem_rdata_i;
         2'd2:    line[71:64] = imem_rdata_i[7:0];
         default: ;
      endcase

      ib = line[47:0];
      case (pc_q[1:0])
         2'd1:    ib = line[55:8];
         2'd2:    ib = line[63:16];
         2'd3:    ib = line[71:24];
         default: ;
      endcase

      dec_icode = ib[7:4];
      dec_ifun  = ib[3:0];
      dec_len   = ins_len(dec_icode);
      // (offset + len - 1) >> 2 is the index of the last word needed
      span      = {2'b00, pc_q[1:0]} + {1'b0, dec_len} - 4'd1;
      dec_last  = (wcnt_q == span[3:2]);

      dec_ra = 4'hF;
      dec_rb = 4'hF;
      if (has_regs(dec_icode)) begin
         dec_ra = ib[15:12];
         dec_rb = ib[11:8];
      end

      case (dec_icode)
         4'h7, 4'h8:       dec_valc = ib[39:8];
         4'h3, 4'h4, 4'h5: dec_valc = ib[47:16];
         default:          dec_valc = '0;
      endcase

      dec_valp = pc_q + {29'd0, dec_len};

      if (dec_icode == 4'h0)
         dec_stat = STAT_HLT;
      else if (dec_icode > 4'hB)
         dec_stat = STAT_INS;
      else
         dec_stat = STAT_AOK;

      fault = imem_ack_i ? imem_err_i : (to_q == TO_LAST);
      done  = fault || (imem_ack_i && dec_last);
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      predpc_d = predpc_q;
      req_d    = req_q;
      addr_d   = addr_q;
      wcnt_d   = wcnt_q;
      to_d     = to_q;
      w0_d     = w0_q;
      w1_d     = w1_q;
      valid_d  = valid_q;
      icode_d  = icode_q;
      ifun_d   = ifun_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      valc_d   = valc_q;
      valp_d   = valp_q;
      stat_d   = stat_q;

      case (state_q)
         S_IDLE: begin
            pc_d    = f_pc_i;
            req_d   = 1'b1;
            addr_d  = {f_pc_i[31:2], 2'b00};
            wcnt_d  = '0;
            to_d    = '0;
            state_d = S_REQ;
         end

         S_REQ: begin
            if (done) begin
               req_d   = 1'b0;
               valid_d = 1'b1;
               to_d    = '0;
               state_d = S_VALID;
               icode_d = dec_icode;
               ifun_d  = dec_ifun;
               ra_d    = dec_ra;
               rb_d    = dec_rb;
               valc_d  = dec_valc;
               valp_d  = dec_valp;
               stat_d  = dec_stat;
               if (fault) begin
                  // icode/ifun survive only if word 0 was already captured
                  if (wcnt_q == 2'd0) begin
                     icode_d = '0;
                     ifun_d  = '0;
                  end
                  ra_d   = 4'hF;
                  rb_d   = 4'hF;
                  valc_d = '0;
                  valp_d = pc_q;
                  stat_d = STAT_ADR;
               end
            end else if (imem_ack_i) begin
               if (wcnt_q == 2'd0)
                  w0_d = imem_rdata_i;
               else
                  w1_d = imem_rdata_i;
               wcnt_d = wcnt_q + 2'd1;
               addr_d = addr_q + 32'd4;
               to_d   = '0;
            end else begin
               to_d = to_q + 8'd1;
            end
         end

         S_WAIT_DRAIN: begin
            // Data of the abandoned read is dropped; a timed-out drain also
            // moves on so the stage cannot wedge on a dead memory.
            if (imem_ack_i || (to_q == TO_LAST)) begin
               req_d   = 1'b1;
               addr_d  = {pc_q[31:2], 2'b00};
               wcnt_d  = '0;
               to_d    = '0;
               state_d = S_REQ;
            end else begin
               to_d = to_q + 8'd1;
            end
         end

         S_VALID: begin
            if (d_ready_i) begin
               valid_d  = 1'b0;
               predpc_d = ((icode_q == 4'h7) || (icode_q == 4'h8)) ? valc_q : valp_q;
               state_d  = (stat_q == STAT_AOK) ? S_IDLE : S_STOPPED;
            end
         end

         S_STOPPED: ;

         default: state_d = S_IDLE;
      endcase

      // Redirect overrides whatever the state logic chose this cycle,
      // including a transfer or the completing ack.
      if (f_redirect_i) begin
         pc_d     = f_pc_i;
         valid_d  = 1'b0;
         predpc_d = predpc_q;
         wcnt_d   = '0;
         to_d     = '0;
         req_d    = 1'b1;
         if (req_q && !imem_ack_i) begin
            addr_d  = addr_q;
            state_d = S_WAIT_DRAIN;
         end else begin
            addr_d  = {f_pc_i[31:2], 2'b00};
            state_d = S_REQ;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         predpc_q <= RESET_PC;
         req_q    <= 1'b0;
         addr_q   <= '0;
         wcnt_q   <= '0;
         to_q     <= '0;
         w0_q     <= '0;
         w1_q     <= '0;
         valid_q  <= 1'b0;
         icode_q  <= '0;
         ifun_q   <= '0;
         ra_q     <= '0;
         rb_q     <= '0;
         valc_q   <= '0;
         valp_q   <= '0;
         stat_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         predpc_q <= predpc_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         wcnt_q   <= wcnt_d;
         to_q     <= to_d;
         w0_q     <= w0_d;
         w1_q     <= w1_d;
         valid_q  <= valid_d;
         icode_q  <= icode_d;
         ifun_q   <= ifun_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         valc_q   <= valc_d;
         valp_q   <= valp_d;
         stat_q   <= stat_d;
      end
   end

   assign F_predPC_o  = predpc_q;
   assign imem_req_o  = req_q;
   assign imem_addr_o = addr_q;
   assign f_valid_o   = valid_q;
   assign f_icode_o   = icode_q;
   assign f_ifun_o    = ifun_q;
   assign f_rA_o      = ra_q;
   assign f_rB_o      = rb_q;
   assign f_valC_o    = valc_q;
   assign f_valP_o    = valp_q;
   assign f_stat_o    = stat_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, scoreboard-based bench for fetch_unit.
// Memory is a 1 KiB byte-addressed array (address bits [9:2] select the word),
// with programmable ack delay, ack enable and error injection.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] f_pc_i;
   logic        f_redirect_i;
   logic [31:0] F_predPC_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic        imem_err_i;
   logic [31:0] imem_rdata_i;
   logic        f_valid_o;
   logic        d_ready_i;
   logic [3:0]  f_icode_o;
   logic [3:0]  f_ifun_o;
   logic [3:0]  f_rA_o;
   logic [3:0]  f_rB_o;
   logic [31:0] f_valC_o;
   logic [31:0] f_valP_o;
   logic [2:0]  f_stat_o;

   fetch_unit #(
      .RESET_PC   (32'h0),
      .TIMEOUT_CYC(255)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .f_pc_i       (f_pc_i),
      .f_redirect_i (f_redirect_i),
      .F_predPC_o   (F_predPC_o),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_err_i   (imem_err_i),
      .imem_rdata_i (imem_rdata_i),
      .f_valid_o    (f_valid_o),
      .d_ready_i    (d_ready_i),
      .f_icode_o    (f_icode_o),
      .f_ifun_o     (f_ifun_o),
      .f_rA_o       (f_rA_o),
      .f_rB_o       (f_rB_o),
      .f_valC_o     (f_valC_o),
      .f_valP_o     (f_valP_o),
      .f_stat_o     (f_stat_o)
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic [31:0] mem_w [256];
   int unsigned mem_delay = 0;
   int unsigned wait_cnt  = 0;
   logic        ack_en    = 1'b1;
   logic        err_mode  = 1'b0;

   assign imem_rdata_i = mem_w[imem_addr_o[9:2]];
   assign imem_ack_i   = imem_req_o && ack_en && (wait_cnt >= mem_delay);
   assign imem_err_i   = imem_ack_i && err_mode;

   always @(posedge clk) begin
      if (imem_req_o && !imem_ack_i) wait_cnt <= wait_cnt + 1;
      else                           wait_cnt <= 0;
   end

   logic [31:0] acked_q[$];
   always @(negedge clk) begin
      if (imem_req_o && imem_ack_i) acked_q.push_back(imem_addr_o);
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [31:0] valc;
      logic [31:0] valp;
      logic [2:0]  stat;
      bit          chk_valp;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_addr_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [31:0] a, input logic [7:0] b);
      mem_w[a[9:2]][{a[1:0], 3'b000} +: 8] = b;
   endtask

   // b holds the instruction bytes, first byte in b[7:0]
   task automatic put(input logic [31:0] a, input int n, input logic [47:0] b);
      for (int i = 0; i < n; i++) wr_byte(a + 32'(i), b[8*i +: 8]);
   endtask

   task automatic push_exp(input logic [3:0] icode, input logic [3:0] ifun,
                           input logic [3:0] ra, input logic [3:0] rb,
                           input logic [31:0] valc, input logic [31:0] valp,
                           input logic [2:0] stat, input bit chk_valp);
      exp_t e;
      e.icode = icode; e.ifun = ifun; e.ra = ra; e.rb = rb;
      e.valc = valc; e.valp = valp; e.stat = stat; e.chk_valp = chk_valp;
      exp_q.push_back(e);
   endtask

   task automatic wait_valid(input int budget, output int lat);
      lat = 0;
      while (!f_valid_o && lat < budget) begin
         tick();
         lat++;
      end
      if (!f_valid_o) chk("valid_timeout", f_valid_o, 1);
   endtask

   task automatic check_out();
      exp_t e;
      e = exp_q.pop_front();
      chk("valid", f_valid_o, 1);
      chk("icode", f_icode_o, e.icode);
      chk("ifun",  f_ifun_o,  e.ifun);
      chk("rA",    f_rA_o,    e.ra);
      chk("rB",    f_rB_o,    e.rb);
      chk("valC",  f_valC_o,  e.valc);
      chk("stat",  f_stat_o,  e.stat);
      if (e.chk_valp) chk("valP", f_valP_o, e.valp);
   endtask

   task automatic check_addrs();
      chk("addr_count", acked_q.size(), exp_addr_q.size());
      for (int i = 0; i < exp_addr_q.size(); i++)
         if (i < acked_q.size()) chk("addr_order", acked_q[i], exp_addr_q[i]);
      acked_q.delete();
      exp_addr_q.delete();
   endtask

   // DUT is in IDLE: the next edge latches pc and raises req
   task automatic start_fetch(input logic [31:0] pc);
      f_pc_i = pc;
      tick();
      chk("req_rise", imem_req_o, 1);
      chk("req_addr", imem_addr_o, {pc[31:2], 2'b00});
   endtask

   task automatic redirect(input logic [31:0] pc, input logic rdy);
      f_pc_i       = pc;
      f_redirect_i = 1'b1;
      d_ready_i    = rdy;
      tick();
      f_redirect_i = 1'b0;
      d_ready_i    = 1'b0;
   endtask

   task automatic accept();
      d_ready_i = 1'b1;
      tick();
      d_ready_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;

      rst          = 1'b1;
      f_pc_i       = '0;
      f_redirect_i = 1'b0;
      d_ready_i    = 1'b0;
      for (int i = 0; i < 256; i++) mem_w[i] = '0;
      repeat (2) tick();

      // reset state
      chk("rst_req",    imem_req_o, 0);
      chk("rst_valid",  f_valid_o,  0);
      chk("rst_predpc", F_predPC_o, 32'h0);
      chk("rst_addr",   imem_addr_o, 0);
      chk("rst_icode",  f_icode_o,  0);
      chk("rst_valc",   f_valC_o,   0);
      chk("rst_stat",   f_stat_o,   0);

      // 1: irmovl at pc 0, two words, zero-wait memory
      put(32'h0, 6, 48'h12345678F230);
      push_exp(4'h3, 4'h0, 4'hF, 4'h2, 32'h12345678, 32'h6, 3'd1, 1'b1);
      exp_addr_q.push_back(32'h0);
      exp_addr_q.push_back(32'h4);
      rst = 1'b0;
      start_fetch(32'h0);
      wait_valid(20, lat);
      chk("t1_latency", lat, 2);
      check_out();
      check_addrs();
      accept();
      chk("t1_predpc", F_predPC_o, 32'h6);
      chk("t1_valid_drop", f_valid_o, 0);

      // 2: irmovl at pc 3 spanning three words
      put(32'h3, 6, 48'hDEADBEEFF330);
      push_exp(4'h3, 4'h0, 4'hF, 4'h3, 32'hDEADBEEF, 32'h9, 3'd1, 1'b1);
      exp_addr_q.push_back(32'h0);
      exp_addr_q.push_back(32'h4);
      exp_addr_q.push_back(32'h8);
      start_fetch(32'h3);
      wait_valid(20, lat);
      chk("t2_latency", lat, 3);
      check_out();
      check_addrs();
      accept();
      chk("t2_predpc", F_predPC_o, 32'h9);

      // 3: jmp at 0x10, D stalls 4 cycles, then predPC takes valC
      put(32'h10, 5, 48'h000000010070);
      push_exp(4'h7, 4'h0, 4'hF, 4'hF, 32'h100, 32'h15, 3'd1, 1'b1);
      exp_addr_q.push_back(32'h10);
      exp_addr_q.push_back(32'h14);
      start_fetch(32'h10);
      wait_valid(20, lat);
      chk("t3_latency", lat, 2);
      check_out();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_hold_valid", f_valid_o, 1);
         chk("t3_hold_icode", f_icode_o, 4'h7);
         chk("t3_hold_valc",  f_valC_o,  32'h100);
      end
      accept();
      chk("t3_predpc", F_predPC_o, 32'h100);
      check_addrs();

      // 4: redirect to 0x40 while the ack for 0x20 is 3 cycles late
      put(32'h20, 1, 48'h10);
      put(32'h40, 2, 48'h1260);
      mem_delay = 3;
      exp_addr_q.push_back(32'h20);
      exp_addr_q.push_back(32'h40);
      start_fetch(32'h20);
      push_exp(4'h6, 4'h0, 4'h1, 4'h2, 32'h0, 32'h42, 3'd1, 1'b1);
      redirect(32'h40, 1'b0);
      chk("t4_valid_clear", f_valid_o, 0);
      chk("t4_drain_req",   imem_req_o, 1);
      chk("t4_drain_addr",  imem_addr_o, 32'h20);
      wait_valid(40, lat);
      check_out();
      // redirect beats a simultaneous transfer
      mem_delay = 0;
      push_exp(4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h21, 3'd1, 1'b1);
      exp_addr_q.push_back(32'h20);
      redirect(32'h20, 1'b1);
      chk("t4_no_transfer", F_predPC_o, 32'h100);
      chk("t4_valid_clear2", f_valid_o, 0);
      chk("t4_req_new", imem_addr_o, 32'h20);
      wait_valid(20, lat);
      chk("t4_latency", lat, 1);
      check_out();
      accept();
      chk("t4_predpc", F_predPC_o, 32'h21);
      check_addrs();

      // 5a: illegal icode -> INS, then STOPPED with no requests
      put(32'h50, 1, 48'hC0);
      push_exp(4'hC, 4'h0, 4'hF, 4'hF, 32'h0, 32'h51, 3'd4, 1'b1);
      exp_addr_q.push_back(32'h50);
      start_fetch(32'h50);
      wait_valid(20, lat);
      chk("t5_latency", lat, 1);
      check_out();
      accept();
      chk("t5_predpc", F_predPC_o, 32'h51);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         f_pc_i = 32'h100 + 32'(i);
         tick();
         if (imem_req_o) n++;
      end
      chk("t5_stopped_req", n, 0);

      // 5b: faulting read -> ADR
      err_mode = 1'b1;
      push_exp(4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h0, 3'd3, 1'b0);
      exp_addr_q.push_back(32'h60);
      redirect(32'h60, 1'b0);
      chk("t5_err_req", imem_req_o, 1);
      wait_valid(20, lat);
      chk("t5_err_latency", lat, 1);
      check_out();
      err_mode = 1'b0;
      accept();

      // 5c: no ack at all -> ADR after 255 cycles, request dropped
      ack_en = 1'b0;
      push_exp(4'h0, 4'h0, 4'hF, 4'hF, 32'h0, 32'h0, 3'd3, 1'b0);
      redirect(32'h70, 1'b0);
      chk("t5_to_req", imem_req_o, 1);
      wait_valid(300, lat);
      chk("t5_to_latency", lat, 255);
      chk("t5_to_req_drop", imem_req_o, 0);
      check_out();
      accept();
      check_addrs();

      // 6: reset in the middle of a pending request
      redirect(32'h80, 1'b0);
      chk("t6_req", imem_req_o, 1);
      tick();
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_req",    imem_req_o, 0);
      chk("t6_rst_valid",  f_valid_o,  0);
      chk("t6_rst_predpc", F_predPC_o, 32'h0);
      ack_en = 1'b1;
      acked_q.delete();
      put(32'h0, 1, 48'h10);
      push_exp(4'h1, 4'h0, 4'hF, 4'hF, 32'h0, 32'h1, 3'd1, 1'b1);
      exp_addr_q.push_back(32'h0);
      tick();
      rst = 1'b0;
      start_fetch(F_predPC_o);
      wait_valid(20, lat);
      chk("t6_latency", lat, 1);
      check_out();
      accept();
      chk("t6_predpc", F_predPC_o, 32'h1);
      check_addrs();

      // 7: 6-byte instruction wrapping past the top of the address space
      put(32'hFFFFFFFD, 6, 48'h44332211F430);
      push_exp(4'h3, 4'h0, 4'hF, 4'h4, 32'h44332211, 32'h3, 3'd1, 1'b1);
      exp_addr_q.push_back(32'hFFFFFFFC);
      exp_addr_q.push_back(32'h0);
      start_fetch(32'hFFFFFFFD);
      wait_valid(20, lat);
      chk("t7_latency", lat, 2);
      check_out();
      accept();
      chk("t7_predpc", F_predPC_o, 32'h3);
      check_addrs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
